// File: rtl/uc_pkg.sv
// Shared definitions for the multicycle control unit: FSM states, opcode
// classes, jump opcodes, ALU-op class prefixes and the op_alu code set.
// Latency: n/a (types and constants only). Backpressure: n/a.
package uc_pkg;

    // Controller states. FETCH is encoded as zero so a cleared register lands there.
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_e;

    // Instruction classes produced by the opcode decoder.
    typedef enum logic [2:0] {
        CL_ILLEGAL = 3'd0,
        CL_ALU_IMM = 3'd1,
        CL_ALU_REG = 3'd2,
        CL_JMP     = 3'd3,
        CL_JZ      = 3'd4,
        CL_JNZ     = 3'd5
    } op_class_e;

    // Jump opcodes (full 6-bit match).
    localparam logic [5:0] OP_JMP = 6'b000100;
    localparam logic [5:0] OP_JZ  = 6'b000101;
    localparam logic [5:0] OP_JNZ = 6'b000110;

    // Immediate ALU ops: opcode[5] set, ALU code in opcode[4:2]. The code 111
    // in that field is reserved, so 111xxx is not an immediate ALU op.
    localparam logic       PFX_ALU_IMM  = 1'b1;
    localparam logic [2:0] IMM_RESERVED = 3'b111;

    // Register ALU ops: opcode[5:3] == 010, ALU code in opcode[2:0].
    localparam logic [2:0] PFX_ALU_REG  = 3'b010;

    // op_alu code space.
    localparam logic [2:0] ALU_OP_0 = 3'b000;
    localparam logic [2:0] ALU_OP_1 = 3'b001;
    localparam logic [2:0] ALU_OP_2 = 3'b010;
    localparam logic [2:0] ALU_OP_3 = 3'b011;
    localparam logic [2:0] ALU_OP_4 = 3'b100;
    localparam logic [2:0] ALU_OP_5 = 3'b101;
    localparam logic [2:0] ALU_OP_6 = 3'b110;
    localparam logic [2:0] ALU_OP_7 = 3'b111;

    // Inactive value driven on op_alu whenever no ALU op executes.
    localparam logic [2:0] ALU_OP_IDLE = ALU_OP_0;

endpackage

// File: rtl/dec_op.sv
// Opcode classifier: maps a 6-bit opcode onto {class, alu_code, legal}.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input every cycle.
// Ports:
//   opcode   in  [5:0]  opcode to classify
//   op_class out [2:0]  op_class_e encoding of the instruction class
//   alu_code out [2:0]  ALU operation for ALU classes, ALU_OP_IDLE otherwise
//   legal    out        1 when the opcode belongs to a known class
module dec_op
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [2:0] op_class,
    output logic [2:0] alu_code,
    output logic       legal
);

    op_class_e cls;

    always_comb begin
        cls      = CL_ILLEGAL;
        alu_code = ALU_OP_IDLE;

        // Immediate is tested first; its prefix (1xxxxx) cannot overlap the
        // register prefix (010xxx) or the jumps (0001xx), so order only
        // matters for readability.
        if ((opcode[5] == PFX_ALU_IMM) && (opcode[4:2] != IMM_RESERVED)) begin
            cls      = CL_ALU_IMM;
            alu_code = opcode[4:2];
        end else if (opcode[5:3] == PFX_ALU_REG) begin
            cls      = CL_ALU_REG;
            alu_code = opcode[2:0];
        end else if (opcode == OP_JMP) begin
            cls = CL_JMP;
        end else if (opcode == OP_JZ) begin
            cls = CL_JZ;
        end else if (opcode == OP_JNZ) begin
            cls = CL_JNZ;
        end
    end

    assign op_class = cls;
    assign legal    = (cls != CL_ILLEGAL);

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control unit: FETCH -> DECODE -> EXEC per instruction, HALT on illegal opcode.
// Latency: 3 cycles per instruction with zero-wait memory, +1 per cycle of mem_ready=0.
// Backpressure: FETCH holds mem_req until mem_ready; mem_ready is ignored in other states.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   opcode, z           IR opcode field (valid the cycle after load_ir), zero flag
//   mem_ready           instruction word present on the bus
//   mem_req, load_ir    fetch request, IR capture strobe
//   load_pc, s_inc      PC update enable, PC source (1 = PC+1, 0 = jump target)
//   s_inm, s_mux_datos  immediate select (tied 0), RF write source (1 = immediate)
//   we3, wez, op_alu    RF write enable, zero-flag write enable, ALU operation
//   halted, instr_cnt   stopped on illegal opcode, retired-instruction counter
module uc_multiciclo
    import uc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        z,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        load_ir,
    output logic        load_pc,
    output logic        s_inc,
    output logic        s_inm,
    output logic        s_mux_datos,
    output logic        we3,
    output logic        wez,
    output logic [2:0]  op_alu,
    output logic        halted,
    output logic [15:0] instr_cnt
);

    state_e      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [15:0] cnt_q, cnt_d;

    logic [5:0]  dec_in;
    logic [2:0]  dec_class;
    logic [2:0]  dec_alu;
    logic        dec_legal;
    op_class_e   cls;

    // One decoder serves both phases: in DECODE it classifies the live IR
    // opcode to pick the next state; in EXEC it works off the latched copy so
    // the controls do not depend on the IR staying stable.
    assign dec_in = (state_q == ST_DECODE) ? opcode : op_q;

    dec_op u_dec_op (
        .opcode   (dec_in),
        .op_class (dec_class),
        .alu_code (dec_alu),
        .legal    (dec_legal)
    );

    assign cls = op_class_e'(dec_class);

    always_comb begin
        // Inactive control values first; states only raise what they need.
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        mem_req     = 1'b0;
        load_ir     = 1'b0;
        load_pc     = 1'b0;
        s_inc       = 1'b1;
        s_inm       = 1'b0;
        s_mux_datos = 1'b0;
        we3         = 1'b0;
        wez         = 1'b0;
        op_alu      = ALU_OP_IDLE;
        halted      = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    load_ir = 1'b1;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                op_d    = opcode;
                state_d = dec_legal ? ST_EXEC : ST_HALT;
            end

            ST_EXEC: begin
                load_pc = 1'b1;
                case (cls)
                    CL_ALU_IMM: begin
                        we3         = 1'b1;
                        wez         = 1'b1;
                        s_mux_datos = 1'b1;
                        op_alu      = dec_alu;
                    end
                    CL_ALU_REG: begin
                        we3    = 1'b1;
                        wez    = 1'b1;
                        op_alu = dec_alu;
                    end
                    CL_JMP:  s_inc = 1'b0;
                    // Taken branch selects the jump target (s_inc=0).
                    CL_JZ:   s_inc = ~z;
                    CL_JNZ:  s_inc = z;
                    default: s_inc = 1'b1;
                endcase
                cnt_d   = cnt_q + 16'd1;
                state_d = ST_FETCH;
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: state_d = ST_FETCH;
        endcase

        // Reset masks every strobe in the cycle it is asserted, even if the
        // register still holds EXEC, so no write or PC update escapes.
        if (reset) begin
            mem_req     = 1'b0;
            load_ir     = 1'b0;
            load_pc     = 1'b0;
            s_inc       = 1'b1;
            s_mux_datos = 1'b0;
            we3         = 1'b0;
            wez         = 1'b0;
            op_alu      = ALU_OP_IDLE;
            halted      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr_cnt = cnt_q;

    // Structural sanity: IR capture only on an answered fetch, and state
    // writes only from EXEC.
    a_load_ir_fetch: assert property (@(posedge clk) disable iff (reset)
        load_ir |-> (mem_req && mem_ready && (state_q == ST_FETCH)));
    a_write_in_exec: assert property (@(posedge clk) disable iff (reset)
        (we3 || wez || load_pc) |-> (state_q == ST_EXEC));

endmodule

// File: tb/tb_uc_multiciclo.sv
// Testbench for uc_multiciclo: table of single-instruction vectors plus
// directed sequences for wait states, back-to-back issue, reset, halt and
// counter wrap.
module tb_uc_multiciclo;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic        z;
    logic        mem_ready;
    logic        mem_req;
    logic        load_ir;
    logic        load_pc;
    logic        s_inc;
    logic        s_inm;
    logic        s_mux_datos;
    logic        we3;
    logic        wez;
    logic [2:0]  op_alu;
    logic        halted;
    logic [15:0] instr_cnt;

    int n_chk = 0;
    int n_err = 0;

    uc_multiciclo dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .z           (z),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .load_ir     (load_ir),
        .load_pc     (load_pc),
        .s_inc       (s_inc),
        .s_inm       (s_inm),
        .s_mux_datos (s_mux_datos),
        .we3         (we3),
        .wez         (wez),
        .op_alu      (op_alu),
        .halted      (halted),
        .instr_cnt   (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] opc;
        logic       zf;
        logic       legal;
        logic       e_we3;
        logic       e_wez;
        logic       e_smux;
        logic [2:0] e_alu;
        logic       e_lpc;
        logic       e_sinc;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mreq_cnt;
        int lir_cnt;

        vecs[0]  = '{6'b101000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 1'b1, 1'b1};
        vecs[1]  = '{6'b111011, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b110, 1'b1, 1'b1};
        vecs[2]  = '{6'b100001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 1'b1};
        vecs[3]  = '{6'b010111, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b111, 1'b1, 1'b1};
        vecs[4]  = '{6'b010010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1};
        vecs[5]  = '{6'b000100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
        vecs[6]  = '{6'b000101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
        vecs[7]  = '{6'b000101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1};
        vecs[8]  = '{6'b000110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1};
        vecs[9]  = '{6'b000110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
        vecs[10] = '{6'b111100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1};
        vecs[11] = '{6'b011000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1};
        vecs[12] = '{6'b000111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1};
        vecs[13] = '{6'b111111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1};
        vecs[14] = '{6'b001010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1};

        reset     = 1'b1;
        opcode    = 6'b101000;
        z         = 1'b0;
        mem_ready = 1'b1;

        // Reset state: enables low even with mem_ready high.
        step();
        @(negedge clk);
        chk("rst.mem_req", 16'(mem_req), 16'd0);
        chk("rst.load_ir", 16'(load_ir), 16'd0);
        chk("rst.load_pc", 16'(load_pc), 16'd0);
        chk("rst.we3", 16'(we3), 16'd0);
        chk("rst.wez", 16'(wez), 16'd0);
        chk("rst.s_inc", 16'(s_inc), 16'd1);
        chk("rst.op_alu", 16'(op_alu), 16'd0);
        chk("rst.halted", 16'(halted), 16'd0);
        chk("rst.instr_cnt", instr_cnt, 16'd0);
        chk("rst.s_inm", 16'(s_inm), 16'd0);

        // Single-instruction vectors from reset with zero-wait memory.
        for (int i = 0; i < 15; i++) begin
            do_reset();
            opcode    = vecs[i].opc;
            z         = vecs[i].zf;
            mem_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d.fetch.mem_req", i), 16'(mem_req), 16'd1);
            chk($sformatf("v%0d.fetch.load_ir", i), 16'(load_ir), 16'd1);
            step();
            @(negedge clk);
            chk($sformatf("v%0d.dec.mem_req", i), 16'(mem_req), 16'd0);
            chk($sformatf("v%0d.dec.load_ir", i), 16'(load_ir), 16'd0);
            chk($sformatf("v%0d.dec.load_pc", i), 16'(load_pc), 16'd0);
            step();
            @(negedge clk);
            chk($sformatf("v%0d.x.we3", i), 16'(we3), 16'(vecs[i].e_we3));
            chk($sformatf("v%0d.x.wez", i), 16'(wez), 16'(vecs[i].e_wez));
            chk($sformatf("v%0d.x.smux", i), 16'(s_mux_datos), 16'(vecs[i].e_smux));
            chk($sformatf("v%0d.x.op_alu", i), 16'(op_alu), 16'(vecs[i].e_alu));
            chk($sformatf("v%0d.x.load_pc", i), 16'(load_pc), 16'(vecs[i].e_lpc));
            chk($sformatf("v%0d.x.s_inc", i), 16'(s_inc), 16'(vecs[i].e_sinc));
            chk($sformatf("v%0d.x.halted", i), 16'(halted), 16'(!vecs[i].legal));
            step();
            @(negedge clk);
            chk($sformatf("v%0d.post.mem_req", i), 16'(mem_req), 16'(vecs[i].legal));
            chk($sformatf("v%0d.post.instr_cnt", i), instr_cnt, 16'(vecs[i].legal));
            chk($sformatf("v%0d.post.halted", i), 16'(halted), 16'(!vecs[i].legal));
        end

        // Wait states: four cycles of mem_ready=0, then ready; mem_ready kept
        // high through DECODE/EXEC must not produce a second load_ir.
        do_reset();
        opcode    = 6'b010111;
        mreq_cnt  = 0;
        lir_cnt   = 0;
        for (int c = 0; c < 7; c++) begin
            mem_ready = (c >= 4);
            @(negedge clk);
            mreq_cnt += int'(mem_req);
            lir_cnt  += int'(load_ir);
            if (c == 6) begin
                chk("ws.x.op_alu", 16'(op_alu), 16'd7);
                chk("ws.x.smux", 16'(s_mux_datos), 16'd0);
                chk("ws.x.we3", 16'(we3), 16'd1);
            end
            step();
        end
        chk("ws.mem_req_cycles", 16'(mreq_cnt), 16'd5);
        chk("ws.load_ir_pulses", 16'(lir_cnt), 16'd1);

        // Back-to-back: load_ir every third cycle, four instructions retired.
        do_reset();
        mem_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            case (c / 3)
                0: opcode = 6'b101100;
                1: opcode = 6'b000100;
                2: opcode = 6'b010001;
                default: opcode = 6'b000101;
            endcase
            @(negedge clk);
            chk($sformatf("b2b.c%0d.load_ir", c), 16'(load_ir), 16'((c % 3) == 0));
            step();
        end
        @(negedge clk);
        chk("b2b.instr_cnt", instr_cnt, 16'd4);

        // Reset asserted in EXEC: strobes suppressed, next cycle is FETCH, counter 0.
        do_reset();
        opcode    = 6'b101000;
        mem_ready = 1'b1;
        repeat (5) step();
        reset = 1'b1;
        @(negedge clk);
        chk("rx.we3", 16'(we3), 16'd0);
        chk("rx.wez", 16'(wez), 16'd0);
        chk("rx.load_pc", 16'(load_pc), 16'd0);
        chk("rx.mem_req", 16'(mem_req), 16'd0);
        chk("rx.s_inc", 16'(s_inc), 16'd1);
        chk("rx.cnt_before", instr_cnt, 16'd1);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rx.after.mem_req", 16'(mem_req), 16'd1);
        chk("rx.after.instr_cnt", instr_cnt, 16'd0);

        // HALT is absorbing: counter frozen, no strobes, only reset exits.
        do_reset();
        opcode    = 6'b010000;
        mem_ready = 1'b1;
        repeat (3) step();
        opcode = 6'b111100;
        repeat (2) step();
        opcode = 6'b101000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("h.c%0d.halted", c), 16'(halted), 16'd1);
            chk($sformatf("h.c%0d.strobes", c),
                16'({mem_req, load_ir, load_pc, we3, wez}), 16'd0);
            chk($sformatf("h.c%0d.instr_cnt", c), instr_cnt, 16'd1);
            step();
        end
        reset = 1'b1;
        @(negedge clk);
        chk("h.rst.halted", 16'(halted), 16'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("h.exit.mem_req", 16'(mem_req), 16'd1);
        chk("h.exit.halted", 16'(halted), 16'd0);
        chk("h.exit.instr_cnt", instr_cnt, 16'd0);

        // Counter wrap: the counter is seeded near the top while the FSM waits
        // in FETCH, then two instructions carry it through FFFF to 0.
        do_reset();
        opcode    = 6'b100100;
        mem_ready = 1'b0;
        force dut.cnt_q = 16'hFFFE;
        step();
        release dut.cnt_q;
        @(negedge clk);
        chk("wrap.seed", instr_cnt, 16'hFFFE);
        mem_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("wrap.ffff", instr_cnt, 16'hFFFF);
        repeat (3) step();
        @(negedge clk);
        chk("wrap.zero", instr_cnt, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
